branch_unit: RTL and testbench



---
 rtl/branch_pkg.sv | 31 +++
 rtl/ret_stack.sv | 63 ++++++
 rtl/branch_unit.sv | 147 ++++++++++++++
 tb/tb_branch_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution stage: width defaults, the
// jump-target lookup table and the priority-resolved operation encoding.
package branch_pkg;

    localparam int BR_L        = 10;
    localparam int BR_LUT_W    = 5;
    localparam int BR_RS_DEPTH = 4;

    // Priority-resolved branch operation for the current cycle.
    typedef enum logic [2:0] {
        BR_NONE,
        BR_COND,
        BR_UNCOND,
        BR_CALL,
        BR_RET
    } br_op_t;

    typedef logic [BR_L-1:0] tgt_lut_t [0:(2**BR_LUT_W)-1];

    // Default table: entry i holds 8*i, wrapped to the PC width.
    function automatic tgt_lut_t build_tgt_lut();
        tgt_lut_t lut;
        for (int i = 0; i < 2**BR_LUT_W; i++) begin
            lut[i] = BR_L'(i * 8);
        end
        return lut;
    endfunction

    localparam tgt_lut_t TGT_LUT = build_tgt_lut();

endpackage

// File: rtl/ret_stack.sv
// Return-address stack: fixed-depth LIFO with a count register.
// The caller never asserts push and pop together; push on full and pop on
// empty are ignored here (the parent flags them as errors).
module ret_stack #(
    parameter int L        = 10,
    parameter int RS_DEPTH = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         push,
    input  logic         pop,
    input  logic [L-1:0] din,
    output logic [L-1:0] top,
    output logic         empty,
    output logic         full
);

    localparam int PTR_W = $clog2(RS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [L-1:0]     mem_q [RS_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] top_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(RS_DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign wr_ptr  = count_q[PTR_W-1:0];
    assign top_ptr = PTR_W'(count_q - CNT_W'(1));
    assign top     = mem_q[top_ptr];

    // Next entry count after this cycle's push or pop.
    always_comb begin
        count_d = count_q;
        if (do_push) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Count register; reset empties the stack.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage write; contents are not reset, only the count is.
    always_ff @(posedge Clk) begin
        if (do_push && !Reset) begin
            mem_q[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/branch_unit.sv
// Branch/jump resolution stage feeding the PC register. BranchAbs/Target are
// combinational; the PC captures them on the next Clk edge. Control priority
// is Ret > Call > BrUncond > BrCond.
// Optional build macro BRANCH_UNIT_STATS_EN adds the TakenCnt counter output.
module branch_unit
    import branch_pkg::*;
#(
    parameter int L        = BR_L,
    parameter int LUT_W    = BR_LUT_W,
    parameter int RS_DEPTH = BR_RS_DEPTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             BrUncond,
    input  logic             BrCond,
    input  logic             Call,
    input  logic             Ret,
    input  logic [LUT_W-1:0] LutIdx,
    input  logic             ALU_flag,
    input  logic [L-1:0]     ProgCtr,
    output logic             BranchAbs,
    output logic [L-1:0]     Target,
    output logic             RsEmpty,
    output logic             RsFull,
    output logic             RsErr
`ifdef BRANCH_UNIT_STATS_EN
    ,
    output logic [15:0]      TakenCnt
`endif
);

    br_op_t       op;
    logic [L-1:0] lut_tgt;
    logic [L-1:0] rs_top;
    logic [L-1:0] ret_addr;
    logic         rs_push;
    logic         rs_pop;
    logic         err_q;
    logic         err_d;

    assign lut_tgt  = L'(TGT_LUT[LutIdx]);
    assign ret_addr = ProgCtr + L'(1);

    // Resolve simultaneous controls down to a single operation.
    always_comb begin
        op = BR_NONE;
        if (Ret) begin
            op = BR_RET;
        end else if (Call) begin
            op = BR_CALL;
        end else if (BrUncond) begin
            op = BR_UNCOND;
        end else if (BrCond) begin
            op = BR_COND;
        end
    end

    // Jump enable and target; reset holds both at zero.
    always_comb begin
        BranchAbs = 1'b0;
        Target    = '0;
        if (!Reset) begin
            unique case (op)
                BR_COND: begin
                    BranchAbs = ALU_flag;
                    Target    = lut_tgt;
                end
                BR_UNCOND, BR_CALL: begin
                    BranchAbs = 1'b1;
                    Target    = lut_tgt;
                end
                BR_RET: begin
                    if (!RsEmpty) begin
                        BranchAbs = 1'b1;
                        Target    = rs_top;
                    end
                end
                default: begin
                    BranchAbs = 1'b0;
                    Target    = '0;
                end
            endcase
        end
    end

    // Stack requests; a reset cycle discards any pending push or pop.
    assign rs_push = !Reset && (op == BR_CALL) && !RsFull;
    assign rs_pop  = !Reset && (op == BR_RET) && !RsEmpty;

    ret_stack #(
        .L        (L),
        .RS_DEPTH (RS_DEPTH)
    ) u_ret_stack (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (rs_push),
        .pop   (rs_pop),
        .din   (ret_addr),
        .top   (rs_top),
        .empty (RsEmpty),
        .full  (RsFull)
    );

    // Error flag sets on call-while-full or return-while-empty and stays set.
    always_comb begin
        err_d = err_q;
        if ((op == BR_CALL && RsFull) || (op == BR_RET && RsEmpty)) begin
            err_d = 1'b1;
        end
    end

    // Sticky error register, cleared only by reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign RsErr = err_q;

`ifdef BRANCH_UNIT_STATS_EN
    logic [15:0] taken_q;
    logic [15:0] taken_d;

    // Saturating count of cycles where a jump is taken.
    always_comb begin
        taken_d = taken_q;
        if (BranchAbs && (taken_q != 16'hFFFF)) begin
            taken_d = taken_q + 16'd1;
        end
    end

    // Taken-jump counter register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            taken_q <= '0;
        end else begin
            taken_q <= taken_d;
        end
    end

    assign TakenCnt = taken_q;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit. A driver applies one step per cycle and
// pushes the hand-computed outputs expected for that cycle; a monitor pops
// and compares at mid-cycle.
module tb_branch_unit;

  localparam int L     = 10;
  localparam int LUT_W = 5;

  logic             clk;
  logic             reset;
  logic             br_uncond;
  logic             br_cond;
  logic             call;
  logic             ret;
  logic [LUT_W-1:0] lut_idx;
  logic             alu_flag;
  logic [L-1:0]     prog_ctr;
  logic             branch_abs;
  logic [L-1:0]     target;
  logic             rs_empty;
  logic             rs_full;
  logic             rs_err;
`ifdef BRANCH_UNIT_STATS_EN
  logic [15:0]      taken_cnt;
`endif

  branch_unit dut (
    .Clk       (clk),
    .Reset     (reset),
    .BrUncond  (br_uncond),
    .BrCond    (br_cond),
    .Call      (call),
    .Ret       (ret),
    .LutIdx    (lut_idx),
    .ALU_flag  (alu_flag),
    .ProgCtr   (prog_ctr),
    .BranchAbs (branch_abs),
    .Target    (target),
    .RsEmpty   (rs_empty),
    .RsFull    (rs_full),
    .RsErr     (rs_err)
`ifdef BRANCH_UNIT_STATS_EN
    ,
    .TakenCnt  (taken_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // Packed entry: {abs, target[9:0], empty, full, err, in_reset, taken[15:0]}
  localparam int EW = 31;
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [15:0]   exp_taken = '0;

  function automatic void check(string name, string field, int unsigned act, int unsigned exp, logic act_known);
    checks++;
    if (!act_known || act != exp) begin
      errors++;
      $display("FAIL %s.%s actual %0d expected %0d", name, field, act, exp);
    end
  endfunction

  // Monitor: compare at mid-cycle whenever the driver has queued an expectation.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [EW-1:0] e;
      string         n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check(n, "BranchAbs", int'(branch_abs), int'(e[30]), !$isunknown(branch_abs));
      check(n, "Target", int'(target), int'(e[29:20]), !$isunknown(target));
      check(n, "RsEmpty", int'(rs_empty), int'(e[19]), !$isunknown(rs_empty));
      check(n, "RsFull", int'(rs_full), int'(e[18]), !$isunknown(rs_full));
      check(n, "RsErr", int'(rs_err), int'(e[17]), !$isunknown(rs_err));
`ifdef BRANCH_UNIT_STATS_EN
      if (!e[16]) begin
        check(n, "TakenCnt", int'(taken_cnt), int'(e[15:0]), !$isunknown(taken_cnt));
      end
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic step(input string name, input logic rst, input logic bru, input logic brc,
                      input logic cl, input logic rt, input int idx, input logic flag,
                      input int pc, input logic e_abs, input int e_tgt,
                      input logic e_empty, input logic e_full, input logic e_err);
    @(posedge clk);
    #1;
    reset     = rst;
    br_uncond = bru;
    br_cond   = brc;
    call      = cl;
    ret       = rt;
    lut_idx   = LUT_W'(idx);
    alu_flag  = flag;
    prog_ctr  = L'(pc);
    exp_q.push_back({e_abs, L'(e_tgt), e_empty, e_full, e_err, rst, exp_taken});
    name_q.push_back(name);
    if (rst) begin
      exp_taken = '0;
    end else if (e_abs && exp_taken != 16'hFFFF) begin
      exp_taken = exp_taken + 16'd1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; br_uncond = 1'b0; br_cond = 1'b0; call = 1'b0; ret = 1'b0;
    lut_idx = '0; alu_flag = 1'b0; prog_ctr = '0;
    repeat (2) @(posedge clk);

    //    name         rst bru brc cal ret idx flg pc    abs tgt emp ful err
    step("rst_hold",   1,  1,  0,  0,  0,  3,  0,  0,    0,  0,  1,  0,  0);
    step("cond_nt",    0,  0,  1,  0,  0,  5,  0,  0,    0,  40, 1,  0,  0);
    step("cond_t",     0,  0,  1,  0,  0,  5,  1,  0,    1,  40, 1,  0,  0);
    step("idle",       0,  0,  0,  0,  0,  5,  1,  0,    0,  0,  1,  0,  0);
    step("call100",    0,  0,  0,  1,  0,  2,  0,  100,  1,  16, 1,  0,  0);
    step("ret101",     0,  0,  0,  0,  1,  2,  0,  0,    1,  101,0,  0,  0);
    step("after_ret",  0,  0,  0,  0,  0,  0,  0,  0,    0,  0,  1,  0,  0);
    step("call10",     0,  0,  0,  1,  0,  1,  0,  10,   1,  8,  1,  0,  0);
    step("call20",     0,  0,  0,  1,  0,  1,  0,  20,   1,  8,  0,  0,  0);
    step("call30",     0,  0,  0,  1,  0,  1,  0,  30,   1,  8,  0,  0,  0);
    step("call40",     0,  0,  0,  1,  0,  1,  0,  40,   1,  8,  0,  0,  0);
    step("call_full",  0,  0,  0,  1,  0,  4,  0,  50,   1,  32, 0,  1,  0);
    step("ret41",      0,  0,  0,  0,  1,  0,  0,  0,    1,  41, 0,  1,  1);
    step("ret31",      0,  0,  0,  0,  1,  0,  0,  0,    1,  31, 0,  0,  1);
    step("ret21",      0,  0,  0,  0,  1,  0,  0,  0,    1,  21, 0,  0,  1);
    step("ret11",      0,  0,  0,  0,  1,  0,  0,  0,    1,  11, 0,  0,  1);
    step("rst_clr",    1,  0,  0,  0,  0,  0,  0,  0,    0,  0,  1,  0,  1);
    step("ret_empty",  0,  0,  0,  0,  1,  7,  0,  0,    0,  0,  1,  0,  0);
    step("uncond24",   0,  1,  0,  0,  0,  3,  0,  0,    1,  24, 1,  0,  1);
    step("call1023",   0,  0,  0,  1,  0,  0,  0,  1023, 1,  0,  1,  0,  1);
    step("ret_wrap",   0,  0,  0,  0,  1,  9,  0,  0,    1,  0,  0,  0,  1);
    step("rst_call",   1,  0,  0,  1,  0,  2,  0,  7,    0,  0,  1,  0,  1);
    step("no_push",    0,  0,  0,  0,  0,  0,  0,  0,    0,  0,  1,  0,  0);
    step("call54",     0,  0,  0,  1,  0,  6,  0,  54,   1,  48, 1,  0,  0);
    step("prio_ret",   0,  1,  1,  1,  1,  9,  1,  200,  1,  55, 0,  0,  0);
    step("prio_after", 0,  0,  0,  0,  0,  0,  0,  0,    0,  0,  1,  0,  0);
    step("prio_unc",   0,  1,  1,  0,  0,  31, 0,  0,    1,  248,1,  0,  0);
    step("prio_cond",  0,  0,  1,  0,  0,  1,  1,  0,    1,  8,  1,  0,  0);
    step("final_idle", 0,  0,  0,  0,  0,  0,  0,  0,    0,  0,  1,  0,  0);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual %0d expected %0d", exp_q.size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
